// File: rtl/cuckoo_pkg.sv
// Shared limits, chime-state encoding and hour conversion for the cuckoo timekeeper.
package cuckoo_pkg;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    typedef enum logic {
        CHIME_IDLE = 1'b0,
        CHIME_PEND = 1'b1
    } chime_state_t;

    function automatic logic bcdInRange(input logic [7:0] value, input logic [7:0] limit);
        return (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) && (value <= limit);
    endfunction

    // 24-hour BCD to 12-hour binary; midnight and noon both strike twelve.
    function automatic logic [3:0] hourTo12(input logic [7:0] bcdHour);
        logic [4:0] bin;
        bin = 5'(bcdHour[7:4]) * 5'd10 + 5'(bcdHour[3:0]);
        if ((bin == 5'd0) || (bin == 5'd12)) begin
            return 4'd12;
        end else if (bin > 5'd12) begin
            return 4'(bin - 5'd12);
        end else begin
            return bin[3:0];
        end
    endfunction

endpackage

// File: rtl/cuckoo_timekeeper_bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after LIMIT and flags the carry.
module bcd_mod_counter
    import cuckoo_pkg::*;
#(
    parameter logic [7:0] LIMIT = SEC_MAX
) (
    input  logic       i_sysclk,
    input  logic       i_rst_n,
    input  logic       i_inc,
    input  logic       i_load,
    input  logic [7:0] i_loadValue,
    output logic [7:0] o_value,
    output logic [7:0] o_incValue,
    output logic       o_carry
);

    logic [7:0] r_value;
    logic       w_atLimit;

    assign w_atLimit = (r_value == LIMIT);
    assign o_carry   = i_inc & w_atLimit;
    assign o_value   = r_value;

    always_comb begin
        if (w_atLimit) begin
            o_incValue = 8'h00;
        end else if (r_value[3:0] == 4'd9) begin
            o_incValue = {r_value[7:4] + 4'd1, 4'd0};
        end else begin
            o_incValue = {r_value[7:4], r_value[3:0] + 4'd1};
        end
    end

    always_ff @(negedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_value <= 8'h00;
        end else if (i_load) begin
            r_value <= i_loadValue;
        end else if (i_inc) begin
            r_value <= o_incValue;
        end
    end

endmodule

// File: rtl/cuckoo_timekeeper.sv
// BCD time-of-day keeper ticked by rising edges of the asynchronous sigClk.
// The hourly chime handshake is built only when CUCKOO_CHIME_EN is defined.
module cuckoo_timekeeper
    import cuckoo_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int CHIME_NOON_ONLY = 0
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       sigClk,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_pulse,
    output logic       set_err,
    output logic       chime_req,
    input  logic       chime_ack,
    output logic [3:0] chime_count,
    output logic       chime_overrun
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_syncPrev;
    logic [SYNC_STAGES:0]   r_fill;
    logic                   r_secPulse;
    logic                   r_setErr;
    logic                   w_rise;
    logic                   w_loadReq;
    logic                   w_loadOk;
    logic                   w_tick;
    logic                   w_ssCarry;
    logic                   w_mmCarry;
    logic                   w_unusedHhCarry;
    logic [7:0]             w_unusedSsNext;
    logic [7:0]             w_unusedMmNext;
    logic [7:0]             w_hhNext;
    logic                   w_chimeEvt;

    // r_fill marks when the edge history holds real samples, so a high level at release is not a tick.
    always_ff @(negedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= '0;
            r_syncPrev <= 1'b0;
            r_fill     <= '0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], sigClk};
            r_syncPrev <= r_sync[SYNC_STAGES-1];
            r_fill     <= {r_fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_rise    = r_sync[SYNC_STAGES-1] & ~r_syncPrev & r_fill[SYNC_STAGES];
    assign set_ready = rst_n;
    assign w_loadReq = set_valid & set_ready;
    assign w_loadOk  = w_loadReq & bcdInRange(set_hh, HOUR_MAX)
                     & bcdInRange(set_mm, MIN_MAX) & bcdInRange(set_ss, SEC_MAX);
    assign w_tick    = w_rise & ~w_loadOk;

    always_ff @(negedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_secPulse <= 1'b0;
            r_setErr   <= 1'b0;
        end else begin
            r_secPulse <= w_tick;
            r_setErr   <= w_loadReq & ~w_loadOk;
        end
    end

    assign sec_pulse = r_secPulse;
    assign set_err   = r_setErr;

    bcd_mod_counter #(.LIMIT(SEC_MAX)) u_ss (
        .i_sysclk(sysclk), .i_rst_n(rst_n), .i_inc(w_tick), .i_load(w_loadOk),
        .i_loadValue(set_ss), .o_value(ss), .o_incValue(w_unusedSsNext), .o_carry(w_ssCarry)
    );

    bcd_mod_counter #(.LIMIT(MIN_MAX)) u_mm (
        .i_sysclk(sysclk), .i_rst_n(rst_n), .i_inc(w_ssCarry), .i_load(w_loadOk),
        .i_loadValue(set_mm), .o_value(mm), .o_incValue(w_unusedMmNext), .o_carry(w_mmCarry)
    );

    bcd_mod_counter #(.LIMIT(HOUR_MAX)) u_hh (
        .i_sysclk(sysclk), .i_rst_n(rst_n), .i_inc(w_mmCarry), .i_load(w_loadOk),
        .i_loadValue(set_hh), .o_value(hh), .o_incValue(w_hhNext), .o_carry(w_unusedHhCarry)
    );

    // A minute carry only happens on a tick, so loads never raise a chime.
    assign w_chimeEvt = w_mmCarry & ((CHIME_NOON_ONLY == 0) | (w_hhNext == 8'h00) | (w_hhNext == 8'h12));

`ifdef CUCKOO_CHIME_EN
    chime_state_t r_chimeState;
    chime_state_t w_chimeNext;
    logic [3:0]   r_chimeCount;
    logic         r_chimeOverrun;

    always_ff @(negedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_chimeState <= CHIME_IDLE;
        end else begin
            r_chimeState <= w_chimeNext;
        end
    end

    always_comb begin
        w_chimeNext = r_chimeState;
        if (w_chimeEvt) begin
            w_chimeNext = CHIME_PEND;
        end else if ((r_chimeState == CHIME_PEND) && chime_ack) begin
            w_chimeNext = CHIME_IDLE;
        end
    end

    // An event landing on an acknowledged cycle replaces the old chime without counting as an overrun.
    always_ff @(negedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_chimeCount   <= 4'd0;
            r_chimeOverrun <= 1'b0;
        end else if (w_chimeEvt) begin
            r_chimeCount <= hourTo12(w_hhNext);
            if ((r_chimeState == CHIME_PEND) && !chime_ack) begin
                r_chimeOverrun <= 1'b1;
            end
        end
    end

    always_comb begin
        chime_req     = (r_chimeState == CHIME_PEND);
        chime_count   = r_chimeCount;
        chime_overrun = r_chimeOverrun;
    end
`else
    logic w_unusedChime;

    assign w_unusedChime = chime_ack ^ w_chimeEvt;
    assign chime_req     = 1'b0;
    assign chime_count   = 4'd0;
    assign chime_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_cuckoo_timekeeper.sv
// Self-checking bench for cuckoo_timekeeper against a seconds-of-day reference model.
module tb_cuckoo_timekeeper;

    localparam int SYNC = 2;
    localparam int NOON = 0;
`ifdef CUCKOO_CHIME_EN
    localparam bit CHIME_ON = 1'b1;
`else
    localparam bit CHIME_ON = 1'b0;
`endif

    logic       sysclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sigClk = 1'b1;
    logic       set_valid = 1'b0;
    logic [7:0] set_hh = 8'h00;
    logic [7:0] set_mm = 8'h00;
    logic [7:0] set_ss = 8'h00;
    logic       chime_ack = 1'b0;
    logic       set_ready;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       sec_pulse;
    logic       set_err;
    logic       chime_req;
    logic [3:0] chime_count;
    logic       chime_overrun;

    int testsRun = 0;
    int testsFailed = 0;

    int mSecs;
    bit mPulse;
    bit mErr;
    bit mPend;
    bit mOverrun;
    int mCount;
    int cyc;
    bit prevLvl;
    int tickQ[$];

    bit         rLvl;
    bit         rValid;
    bit         rAck;
    logic [7:0] rH;
    logic [7:0] rM;
    logic [7:0] rS;

    always #5 sysclk = ~sysclk;

    cuckoo_timekeeper #(.SYNC_STAGES(SYNC), .CHIME_NOON_ONLY(NOON)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .sigClk(sigClk),
        .set_valid(set_valid), .set_ready(set_ready),
        .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .hh(hh), .mm(mm), .ss(ss), .sec_pulse(sec_pulse), .set_err(set_err),
        .chime_req(chime_req), .chime_ack(chime_ack),
        .chime_count(chime_count), .chime_overrun(chime_overrun)
    );

    function automatic logic [7:0] toBcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int bcdToInt(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit fieldOk(input logic [7:0] v, input int limit);
        return (int'(v[7:4]) < 10) && (int'(v[3:0]) < 10) && (bcdToInt(v) <= limit);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic checkCycle(input string tag, input bit inReset);
        checkOutput({tag, " hh"}, 32'(hh), 32'(toBcd(mSecs / 3600)));
        checkOutput({tag, " mm"}, 32'(mm), 32'(toBcd((mSecs / 60) % 60)));
        checkOutput({tag, " ss"}, 32'(ss), 32'(toBcd(mSecs % 60)));
        checkOutput({tag, " sec_pulse"}, 32'(sec_pulse), 32'(mPulse));
        checkOutput({tag, " set_err"}, 32'(set_err), 32'(mErr));
        checkOutput({tag, " set_ready"}, 32'(set_ready), 32'(!inReset));
        checkOutput({tag, " chime_req"}, 32'(chime_req), CHIME_ON ? 32'(mPend) : 32'd0);
        checkOutput({tag, " chime_count"}, 32'(chime_count), CHIME_ON ? 32'(mCount) : 32'd0);
        checkOutput({tag, " chime_overrun"}, 32'(chime_overrun), CHIME_ON ? 32'(mOverrun) : 32'd0);
    endtask

    task automatic modelReset();
        mSecs = 0;
        mPulse = 1'b0;
        mErr = 1'b0;
        mPend = 1'b0;
        mOverrun = 1'b0;
        mCount = 0;
        tickQ.delete();
    endtask

    // Called at a posedge: drive one cycle of inputs, predict the next negedge, then check at the following posedge.
    task automatic applyStimulus(input bit lvl, input bit valid, input logic [7:0] h, input logic [7:0] m,
                                 input logic [7:0] s, input bit ack, input string tag);
        bit tickNow;
        bit loadOk;
        bit evt;
        int hr;
        sigClk = lvl;
        set_valid = valid;
        set_hh = h;
        set_mm = m;
        set_ss = s;
        chime_ack = ack;
        tickNow = 1'b0;
        evt = 1'b0;
        if (tickQ.size() > 0 && tickQ[0] == cyc + 1) begin
            tickNow = 1'b1;
            void'(tickQ.pop_front());
        end
        loadOk = valid && fieldOk(h, 23) && fieldOk(m, 59) && fieldOk(s, 59);
        mErr = valid && !loadOk;
        mPulse = 1'b0;
        if (loadOk) begin
            mSecs = bcdToInt(h) * 3600 + bcdToInt(m) * 60 + bcdToInt(s);
        end else if (tickNow) begin
            mPulse = 1'b1;
            mSecs = (mSecs + 1) % 86400;
            evt = (mSecs % 3600 == 0) && (NOON == 0 || mSecs % 43200 == 0);
        end
        if (evt) begin
            if (mPend && !ack) mOverrun = 1'b1;
            mPend = 1'b1;
            hr = mSecs / 3600;
            mCount = (hr % 12 == 0) ? 12 : hr % 12;
        end else if (mPend && ack) begin
            mPend = 1'b0;
        end
        if (lvl && !prevLvl && cyc >= 1) tickQ.push_back(cyc + SYNC + 1);
        prevLvl = lvl;
        @(posedge sysclk);
        cyc++;
        checkCycle(tag, 1'b0);
    endtask

    task automatic idle(input int n, input bit lvl, input bit ack, input string tag);
        repeat (n) applyStimulus(lvl, 1'b0, 8'h00, 8'h00, 8'h00, ack, tag);
    endtask

    task automatic loadTime(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input string tag);
        applyStimulus(sigClk, 1'b1, h, m, s, 1'b0, tag);
    endtask

    task automatic secondEdge(input string tag);
        idle(2, 1'b0, 1'b0, tag);
        idle(SYNC + 2, 1'b1, 1'b0, tag);
    endtask

    task automatic doReset(input string tag);
        @(posedge sysclk);
        rst_n = 1'b0;
        modelReset();
        #1 checkCycle({tag, " async"}, 1'b1);
        repeat (3) begin
            @(posedge sysclk);
            checkCycle({tag, " hold"}, 1'b1);
        end
        @(posedge sysclk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        cyc = 0;
        prevLvl = 1'b1;
        doReset("reset");
        idle(10, 1'b1, 1'b0, "held high");

        loadTime(8'h23, 8'h59, 8'h58, "load 23:59:58");
        secondEdge("to 23:59:59");
        secondEdge("wrap midnight");
        idle(3, 1'b1, 1'b0, "midnight pend");
        idle(1, 1'b1, 1'b1, "midnight ack");
        idle(2, 1'b1, 1'b0, "after ack");

        loadTime(8'h24, 8'h10, 8'h10, "bad hh");
        idle(2, 1'b1, 1'b0, "after bad hh");
        loadTime(8'h12, 8'h30, 8'h1A, "bad ss");
        idle(2, 1'b1, 1'b0, "after bad ss");

        loadTime(8'h13, 8'h59, 8'h59, "load 13:59:59");
        secondEdge("to 14:00");
        idle(5, 1'b1, 1'b0, "ack withheld");
        idle(1, 1'b1, 1'b1, "ack 2");
        idle(2, 1'b1, 1'b0, "req drop");

        loadTime(8'h13, 8'h59, 8'h59, "overrun a");
        secondEdge("first hour");
        loadTime(8'h14, 8'h59, 8'h59, "overrun b");
        secondEdge("second hour");
        idle(2, 1'b1, 1'b0, "overrun held");
        idle(1, 1'b1, 1'b1, "overrun ack");

        // Load issued on the exact cycle the tick lands; the load must win.
        idle(2, 1'b0, 1'b0, "coincide low");
        idle(1, 1'b1, 1'b0, "coincide rise");
        idle(SYNC - 1, 1'b1, 1'b0, "coincide wait");
        loadTime(8'h08, 8'h15, 8'h00, "coincide load");
        idle(SYNC + 2, 1'b1, 1'b0, "coincide after");

        loadTime(8'h14, 8'h59, 8'h59, "ack race a");
        secondEdge("ack race pend");
        loadTime(8'h15, 8'h59, 8'h59, "ack race b");
        idle(2, 1'b0, 1'b0, "ack race low");
        idle(1, 1'b1, 1'b0, "ack race rise");
        idle(SYNC - 1, 1'b1, 1'b0, "ack race wait");
        idle(1, 1'b1, 1'b1, "ack race hit");
        idle(3, 1'b1, 1'b0, "ack race repend");
        idle(1, 1'b1, 1'b1, "ack race clear");

        loadTime(8'h16, 8'h59, 8'h59, "reset pend");
        secondEdge("reset pend edge");
        doReset("mid reset");
        idle(10, 1'b1, 1'b0, "post reset");

        for (int i = 0; i < 2000; i++) begin
            rLvl = ($urandom_range(0, 2) == 0) ? ~sigClk : sigClk;
            rValid = ($urandom_range(0, 39) == 0);
            rAck = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) begin
                rH = toBcd($urandom_range(0, 23));
                rM = 8'h59;
                rS = toBcd($urandom_range(50, 59));
            end else begin
                rH = 8'($urandom);
                rM = 8'($urandom);
                rS = 8'($urandom);
            end
            applyStimulus(rLvl, rValid, rH, rM, rS, rAck, "random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
